// File: rtl/rr_mux16.sv
// Round-robin / forced-select N:1 multiplexer with a single registered output slot.
// in_ready is combinational; out_valid, out_data and out_chan come straight from registers.
module rr_mux16 #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SW-1:0]             sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SW-1:0]             out_chan
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [SW-1:0]    ptr, ptr_n;
    logic [SW-1:0]    chan_n;
    logic [WIDTH-1:0] data_n;
    logic [SW-1:0]    gnt_idx;
    logic [SW-1:0]    cand;
    logic             gnt_any;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] data_sel;

    assign out_valid = (state == FULL);
    assign can_load  = (state == EMPTY) || out_ready;
    // Gating with rst_n keeps in_ready low while reset is held.
    assign xfer      = gnt_any && can_load && rst_n;

    // Arbitration: descending scan so the nearest valid channel after ptr wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        if (mode) begin
            gnt_idx = sel;
            gnt_any = in_valid[sel];
        end else begin
            for (int i = int'(CHANNELS); i >= 1; i--) begin
                cand = ptr + SW'(i);
                if (in_valid[cand]) begin
                    gnt_idx = cand;
                    gnt_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        data_sel = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (gnt_idx == SW'(c)) begin
                in_ready[c] = xfer;
                data_sel    = in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: load on transfer, drain when downstream takes the word.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        data_n  = out_data;
        chan_n  = out_chan;
        case (state)
            EMPTY: if (xfer) state_n = FULL;
            FULL: begin
                if (xfer)           state_n = FULL;
                else if (out_ready) state_n = EMPTY;
            end
            default: state_n = EMPTY;
        endcase
        if (xfer) begin
            data_n = data_sel;
            chan_n = gnt_idx;
            ptr_n  = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ptr      <= SW'(CHANNELS - 1);
            out_data <= '0;
            out_chan <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            out_data <= data_n;
            out_chan <= chan_n;
        end
    end

endmodule

// File: tb/tb_rr_mux16.sv
// Directed and random checks of rr_mux16 against a transaction-level reference model.
module tb_rr_mux16;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CH    = 8;
    localparam int unsigned SW    = 3;

    logic                clk;
    logic                rst_n;
    logic [CH-1:0]       in_valid;
    logic [CH*WIDTH-1:0] in_data;
    logic [CH-1:0]       in_ready;
    logic                mode;
    logic [SW-1:0]       sel;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [SW-1:0]       out_chan;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit             m_valid;
    logic [WIDTH-1:0] m_data;
    int             m_chan;
    int             m_ptr;

    rr_mux16 #(.WIDTH(WIDTH), .CHANNELS(CH), .SW(SW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mode     (mode),
        .sel      (sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_chan (out_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_ptr   = CH - 1;
    endtask

    function automatic void model_grant(output int g, output bit any);
        int c;
        g   = 0;
        any = 1'b0;
        if (mode) begin
            g   = int'(sel);
            any = in_valid[sel];
        end else begin
            for (int k = 1; k <= int'(CH); k++) begin
                c = (m_ptr + k) % CH;
                if (!any && in_valid[c]) begin
                    g   = c;
                    any = 1'b1;
                end
            end
        end
    endfunction

    task automatic rand_data();
        for (int c = 0; c < int'(CH); c++) in_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
    endtask

    // One clock: check combinational/held outputs, advance model, check registered outputs.
    task automatic cyc();
        int g;
        bit any;
        bit xfer;
        logic [CH-1:0] exp_rdy;
        #2;
        model_grant(g, any);
        xfer    = any && (!m_valid || out_ready);
        exp_rdy = xfer ? CH'(1 << g) : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid_pre", 32'(out_valid), 32'(m_valid));
        @(posedge clk);
        #1;
        if (xfer) begin
            m_valid = 1'b1;
            m_data  = in_data[g*WIDTH +: WIDTH];
            m_chan  = g;
            m_ptr   = g;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_chan", 32'(out_chan), 32'(m_chan));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        rand_data();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_in_ready", 32'(in_ready), 32'd0);
        chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_chan", 32'(out_chan), 32'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    int seq33[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int seq34[6] = '{0, 2, 7, 0, 2, 7};

    initial begin
        in_data = '0;
        model_reset();

        // Reset then full rotation from channel 0
        do_reset();
        for (int k = 0; k < 9; k++) begin
            rand_data();
            cyc();
            chk("rr_rotate", 32'(out_chan), 32'(seq33[k]));
        end

        // Fairness over a sparse request pattern
        do_reset();
        in_valid = 8'b1000_0101;
        for (int k = 0; k < 6; k++) begin
            rand_data();
            cyc();
            chk("rr_fair", 32'(out_chan), 32'(seq34[k]));
        end

        // Backpressure: hold 16'hABCD from channel 4 for five cycles
        do_reset();
        in_valid = 8'b0001_0000;
        in_data[4*WIDTH +: WIDTH] = 16'hABCD;
        cyc();
        chk("bp_load_chan", 32'(out_chan), 32'd4);
        out_ready = 1'b0;
        in_valid  = '1;
        for (int k = 0; k < 5; k++) begin
            rand_data();
            cyc();
            chk("bp_hold_data", 32'(out_data), 32'hABCD);
            chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_next_chan", 32'(out_chan), 32'd5);

        // Forced select with the chosen channel idle, then active
        mode     = 1'b1;
        sel      = 3'd3;
        in_valid = 8'b0000_0110;
        cyc();
        chk("forced_idle_drain", 32'(out_valid), 32'd0);
        in_valid = 8'b0000_1110;
        rand_data();
        cyc();
        chk("forced_grant3", 32'(out_chan), 32'd3);

        // Forced grant of 5, then back to round-robin
        sel      = 3'd5;
        in_valid = '1;
        rand_data();
        cyc();
        chk("forced_grant5", 32'(out_chan), 32'd5);
        mode = 1'b0;
        rand_data();
        cyc();
        chk("mode_switch_chan", 32'(out_chan), 32'd6);

        // Asynchronous reset between edges while FULL
        chk("pre_async_full", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        rand_data();
        cyc();
        chk("post_reset_grant", 32'(out_chan), 32'd0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            in_valid  = CH'($urandom);
            mode      = ($urandom_range(0, 3) == 0);
            sel       = SW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
